// File: rtl/display_arbiter_pkg.sv
// Shared constants for the display arbiter:
// segment code table, blank code and scan divider default.
package display_arbiter_pkg;

    localparam int SCAN_DIV_DEFAULT = 100000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 are blank.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

endpackage

// File: rtl/display_arbiter_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Invalid entries and non-BCD values are blank.
module seg7_decode
    import display_arbiter_pkg::*;
(
    input  logic       i_valid,
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    // Table lookup, blank when the entry is empty
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_valid) begin
            o_seg = SEG_TABLE[i_value];
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Two-port round-robin writer into an 8-digit buffer,
// scanned out onto a multiplexed 7-segment display.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       req0,
    input  logic [2:0] addr0,
    input  logic [3:0] val0,
    output logic       ack0,
    input  logic       req1,
    input  logic [2:0] addr1,
    input  logic [3:0] val1,
    output logic       ack1,
    output logic [7:0] sel,
    output logic [6:0] data
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

    logic [7:0]      r_valid;
    logic [7:0][3:0] r_val;
    logic            r_prio;
    logic            r_ack0;
    logic            r_ack1;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_sel;
    logic [6:0]      r_data;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_wr;
    logic [2:0]      w_waddr;
    logic [3:0]      w_wval;
    logic [6:0]      w_seg;
    logic [7:0]      w_sel;

    // Grant: lone requester wins; on a tie r_prio picks (0 favours req0)
    always_comb begin
        w_gnt0  = req0 & (~req1 | ~r_prio);
        w_gnt1  = req1 & (~req0 | r_prio);
        w_wr    = ~clr & (w_gnt0 | w_gnt1);
        w_waddr = w_gnt0 ? addr0 : addr1;
        w_wval  = w_gnt0 ? val0 : val1;
        w_sel   = ~(8'h80 >> r_idx);
    end

    // Buffer write, ack pulse and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_val   <= '0;
            r_prio  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else if (clr) begin
            r_valid <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            if (w_wr) begin
                r_valid[w_waddr] <= 1'b1;
                r_val[w_waddr]   <= w_wval;
                r_prio           <= w_gnt0;
            end
        end
    end

    // Prescaler and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (r_cnt == TERM) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    seg7_decode u_dec (
        .i_valid (r_valid[r_idx]),
        .i_value (r_val[r_idx]),
        .o_seg   (w_seg)
    );

    // Registered display drive for the current scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= 8'hFF;
            r_data <= SEG_BLANK;
        end else begin
            r_sel  <= w_sel;
            r_data <= w_seg;
        end
    end

    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign sel  = r_sel;
    assign data = r_data;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (SCAN_DIV=4):
// vector table, directed corner cases, random vs. model.
module tb_display_arbiter;

    localparam int D = 4;

    localparam logic [6:0] TB_SEG [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic       clk = 1'b0;
    logic       rst, clr;
    logic       req0, req1;
    logic [2:0] addr0, addr1;
    logic [3:0] val0, val1;
    logic       ack0, ack1;
    logic [7:0] sel;
    logic [6:0] data;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic       m_valid [8];
    logic [3:0] m_val   [8];
    logic       m_fav1;
    int         m_t;
    logic       m_ack0, m_ack1;
    logic [7:0] m_sel;
    logic [6:0] m_data;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       req0;
        logic [2:0] addr0;
        logic [3:0] val0;
        logic       req1;
        logic [2:0] addr1;
        logic [3:0] val1;
        logic       ack0;
        logic       ack1;
    } vec_t;

    vec_t vecs [10];

    display_arbiter #(.SCAN_DIV(D)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req0(req0), .addr0(addr0), .val0(val0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .val1(val1), .ack1(ack1),
        .sel(sel), .data(data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Spec-level model: outputs show the digit whose slot was
    // active one edge earlier; slot = (edges since reset / D) mod 8.
    task automatic model_step();
        int idx;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0;
                m_val[i]   = 4'd0;
            end
            m_fav1 = 1'b0;
            m_t    = 0;
            m_ack0 = 1'b0;
            m_ack1 = 1'b0;
            m_sel  = 8'hFF;
            m_data = 7'h7F;
        end else begin
            idx    = (m_t / D) % 8;
            m_sel  = 8'hFF;
            m_sel[7 - idx] = 1'b0;
            m_data = m_valid[idx] ? TB_SEG[m_val[idx]] : 7'h7F;
            m_t++;
            m_ack0 = 1'b0;
            m_ack1 = 1'b0;
            if (clr) begin
                for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            end else if (req0 || req1) begin
                if (req0 && (!req1 || !m_fav1)) begin
                    m_ack0 = 1'b1;
                    m_valid[addr0] = 1'b1;
                    m_val[addr0]   = val0;
                    m_fav1 = 1'b1;
                end else begin
                    m_ack1 = 1'b1;
                    m_valid[addr1] = 1'b1;
                    m_val[addr1]   = val1;
                    m_fav1 = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("m_ack0", {7'd0, ack0}, {7'd0, m_ack0});
        chk("m_ack1", {7'd0, ack1}, {7'd0, m_ack1});
        chk("m_sel", sel, m_sel);
        chk("m_data", {1'b0, data}, {1'b0, m_data});
    endtask

    task automatic wait_sel(input logic [7:0] target, input string name);
        bit hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            tick();
            if (sel == target) hit = 1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: sel never reached %h (last %h)",
                     name, target, sel);
        end
    endtask

    task automatic idle_inputs();
        clr = 0; req0 = 0; req1 = 0;
        addr0 = 0; addr1 = 0; val0 = 0; val1 = 0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 1, 3'd4, 4'd5, 0, 3'd0, 4'd0, 1, 0};
        vecs[1] = '{0, 0, 0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 0};
        vecs[2] = '{0, 0, 1, 3'd6, 4'd6, 1, 3'd7, 4'd7, 0, 1};
        vecs[3] = '{0, 0, 1, 3'd6, 4'd8, 1, 3'd7, 4'd9, 1, 0};
        vecs[4] = '{0, 0, 0, 3'd0, 4'd0, 1, 3'd3, 4'd1, 0, 1};
        vecs[5] = '{0, 1, 1, 3'd1, 4'd1, 1, 3'd2, 4'd2, 0, 0};
        vecs[6] = '{0, 0, 1, 3'd1, 4'd1, 1, 3'd2, 4'd2, 1, 0};
        vecs[7] = '{1, 1, 1, 3'd1, 4'd1, 1, 3'd2, 4'd2, 0, 0};
        vecs[8] = '{0, 0, 1, 3'd0, 4'd2, 1, 3'd0, 4'd3, 1, 0};
        vecs[9] = '{0, 0, 1, 3'd0, 4'd2, 1, 3'd0, 4'd3, 0, 1};

        rst = 1;
        idle_inputs();
        m_t = 0;
        tick();
        tick();
        chk("rst_sel", sel, 8'hFF);
        chk("rst_data", {1'b0, data}, 8'h7F);
        chk("rst_acks", {6'd0, ack1, ack0}, 8'h00);

        // reset release: slow sel walk, blank data
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < D; j++) begin
                tick();
                chk("walk_sel", sel, ~(8'h80 >> i));
                chk("walk_data", {1'b0, data}, 8'h7F);
            end
        end

        // single write to digit 0
        req0 = 1; addr0 = 3'd0; val0 = 4'd3;
        tick();
        chk("wr0_ack0", {7'd0, ack0}, 8'd1);
        req0 = 0;
        tick();
        chk("wr0_ack0_drop", {7'd0, ack0}, 8'd0);
        wait_sel(8'h7F, "wr0_sel");
        chk("wr0_data", {1'b0, data}, {1'b0, 7'b0110000});

        // non-BCD value shows blank
        req1 = 1; addr1 = 3'd5; val1 = 4'hC;
        tick();
        chk("wrC_ack1", {7'd0, ack1}, 8'd1);
        req1 = 0;
        wait_sel(8'hFB, "wrC_sel");
        chk("wrC_data", {1'b0, data}, 8'h7F);

        // clr coincident with req1
        clr = 1; req1 = 1; addr1 = 3'd1; val1 = 4'd7;
        tick();
        chk("clr_ack1", {7'd0, ack1}, 8'd0);
        clr = 0;
        tick();
        chk("clr_after_ack1", {7'd0, ack1}, 8'd1);
        req1 = 0;
        wait_sel(8'h7F, "clr_sel0");
        chk("clr_d0_blank", {1'b0, data}, 8'h7F);
        wait_sel(8'hBF, "clr_sel1");
        chk("clr_d1", {1'b0, data}, {1'b0, 7'b1111000});
        wait_sel(8'hFB, "clr_sel5");
        chk("clr_d5_blank", {1'b0, data}, 8'h7F);

        // both held on the same address: acks alternate
        req0 = 1; addr0 = 3'd2; val0 = 4'd1;
        req1 = 1; addr1 = 3'd2; val1 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_ack0", {7'd0, ack0}, {7'd0, ~i[0]});
            chk("rr_ack1", {7'd0, ack1}, {7'd0, i[0]});
        end
        req0 = 0; req1 = 0;
        wait_sel(8'hDF, "rr_sel2");
        chk("rr_data", {1'b0, data}, {1'b0, 7'b0100100});

        // vector table
        for (int v = 0; v < 10; v++) begin
            rst = vecs[v].rst; clr = vecs[v].clr;
            req0 = vecs[v].req0; addr0 = vecs[v].addr0;
            val0 = vecs[v].val0;
            req1 = vecs[v].req1; addr1 = vecs[v].addr1;
            val1 = vecs[v].val1;
            tick();
            chk("vec_ack0", {7'd0, ack0}, {7'd0, vecs[v].ack0});
            chk("vec_ack1", {7'd0, ack1}, {7'd0, vecs[v].ack1});
        end
        idle_inputs();
        rst = 0;

        // mid-scan reset with digits loaded
        for (int a = 0; a < 8; a++) begin
            req0 = 1; addr0 = 3'(a); val0 = 4'(a);
            tick();
        end
        req0 = 0;
        for (int k = 0; k < 6; k++) tick();
        rst = 1;
        tick();
        chk("mrst_sel", sel, 8'hFF);
        chk("mrst_data", {1'b0, data}, 8'h7F);
        rst = 0;
        tick();
        chk("mrst_sel0", sel, 8'h7F);
        for (int k = 0; k < 8 * D; k++) begin
            tick();
            chk("mrst_blank", {1'b0, data}, 8'h7F);
        end

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            req0  = $urandom_range(0, 1);
            req1  = $urandom_range(0, 1);
            addr0 = 3'($urandom);
            addr1 = 3'($urandom);
            val0  = 4'($urandom);
            val1  = 4'($urandom_range(0, 11));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles each digit is shown; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clr  input  1  synchronous clear of all eight digit entries.
REQ-005 req0  input  1  requester 0 write request, held until ack0.
REQ-006 addr0  input  3  requester 0 digit index (0 = leftmost, sel[7]).
REQ-007 val0  input  4  requester 0 BCD value.
REQ-008 ack0  output  1  one-cycle pulse; requester 0 write committed.
REQ-009 req1, addr1, val1, ack1 SHALL be identical in width and meaning to the requester 0 ports.
REQ-010 sel  output  8  active-low digit enable, one-hot-low.
REQ-011 data  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-012 Digit buffer: 8 entries, each a valid bit plus a 4-bit value; valid=0 means blank.
REQ-013 At most one buffer write per cycle.
REQ-014 Grant rule: only one req high -> that requester wins; both high -> round-robin, the requester not granted last wins.
REQ-015 The winner's entry SHALL be written (valid=1, value=valN) on the same edge that registers ackN=1; ackN SHALL be high for exactly that one cycle.
REQ-016 reqN still high in the cycle after ackN SHALL be treated as a new request (requesters drop req on ack).
REQ-017 clr=1 SHALL clear every entry's valid bit, block all writes and force ack0=ack1=0 that cycle; pending requests are granted after clr falls.
REQ-018 Prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and the 3-bit scan index increments, wrapping 7->0.
REQ-019 sel and data are registered; they reflect the new scan index one cycle after the index changes.
REQ-020 sel SHALL drive low only bit (7-index).
REQ-021 data: valid entry with value 0..9 -> standard active-low digit code (0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000); value 10..15 or invalid entry -> 7'b1111111.
REQ-022 A write to the currently scanned digit SHALL appear on data no later than 2 cycles after the ack edge.
REQ-023 Both requesters targeting the same address: only the winner writes; the loser is served next cycle and overwrites.

Reset
REQ-024 rst=1 SHALL set sel=8'hFF, data=7'h7F, ack0=ack1=0, all entries invalid, prescaler=0, scan index=0, round-robin favouring requester 0.
REQ-025 rst SHALL override clr and any in-flight request; no ack is issued during or on the cycle rst is high.
REQ-026 After rst falls, the first digit (sel=8'b0111_1111) is enabled one cycle later.

Structure
REQ-027 Shared package holds the segment code table, the blank code 7'h7F, and the SCAN_DIV default.
REQ-028 Single sub-module seg7_decode: combinational {valid, value} -> 7-bit segment code per REQ-021.

Verification (SCAN_DIV=4)
REQ-029 Reset release with no requests -> sel walks 7F,BF,DF,...,FE every 4 cycles, data stays 7F throughout.
REQ-030 req0 with addr0=0, val0=3 -> ack0 one cycle; while sel=8'b0111_1111, data=7'b0110000.
REQ-031 req0 and req1 held continuously, each with addr=2 -> acks alternate 0,1,0,1; entry 2 ends holding the value of the last ack.
REQ-032 Write val1=4'hC to addr1=5 -> ack1 issued; when sel=8'b1111_1011, data=7'h7F.
REQ-033 clr asserted in the same cycle as req1 -> no ack that cycle, all digits blank, ack1 the cycle after clr falls.
REQ-034 rst asserted mid-scan with digits loaded -> next cycle sel=FF, data=7F, all entries blank, scan restarts at index 0.
